hwint_ctrl: RTL and testbench
=============================

// Module: hwint_ctrl
// PURPOSE
//  Interrupt controller feeding CP0's HWInt[7:2]: synchronises device IRQs, latches pending, masks, picks one
//  winner by fixed priority and holds it on hwint until CP0 accepts; tracks in-service source until eret commits.
//  Sits between bridge/devices and CP0; configured by sw/lw through the bridge register port.
// PARAMETERS
//  NSRC   6   number of IRQ sources; source i drives hwint bit (i+2); max 6
// PORTS
//  clk          in   1     clock
//  reset        in   1     reset
//  irq_in       in   NSRC  raw device requests, asynchronous, active-high
//  exc_taken    in   1     1-cycle pulse: CP0 entered handler for an interrupt (exc_int with ExcCode 0)
//  eret_commit  in   1     1-cycle pulse: eret retired in W
//  reg_we       in   1     register write strobe (bridge, M stage)
//  reg_addr     in   2     word index: 0 MASK, 1 PEND, 2 EDGE, 3 ISR
//  reg_wdata    in   32    write data
//  reg_rdata    out  32    read data, combinational on reg_addr
//  hwint        out  6     to CP0 HWInt[7:2]; one-hot or zero
//  busy         out  1     a source is in service
// BEHAVIOUR
//  Reset: reset synchronous, active-high; clock clk. All regs, hwint, busy, ISR, PEND, MASK, EDGE = 0; FSM IDLE.
//  Sync: irq_in through 2 flops -> irq_s; irq visible in PEND 3 cycles after input edge, earliest hwint cycle 4.
//  PEND[i]: level mode = irq_s[i] (W1C ignored); edge mode = set on irq_s rising, cleared by W1C or by exc_taken
//   when i is winner; set and clear same cycle -> set wins (new edge not lost).
//  Eligible = PEND & MASK. Winner = lowest index eligible (bit 0 highest priority).
//  FSM:
//   IDLE: hwint=0. Eligible!=0 -> REQ, latching winner one-hot into WIN.
//   REQ: hwint=WIN, held stable (no re-arbitration even if higher source arrives).
//    exc_taken -> SERVICE, ISR=WIN, busy=1. Else WIN no longer eligible (level drop, mask, W1C) -> IDLE.
//    exc_taken and eligibility drop same cycle -> exc_taken wins.
//   SERVICE: hwint=0 (no nesting); pending keeps accumulating. eret_commit -> IDLE, ISR=0, busy=0.
//  eret_commit in IDLE/REQ and exc_taken in IDLE/SERVICE are ignored (no state change).
//  Registers: MASK rw [NSRC-1:0]; PEND r, W1C; EDGE rw; ISR ro; unused bits read 0; writes take effect next cycle.
//  reg_we to ISR: no effect. Reset mid-REQ/SERVICE: returns to IDLE, drops hwint next edge.
// CONFIGURATION
//  HWINT_EDGE_EN defined: EDGE register implemented, per-source edge/level select (1 = edge).
//  Undefined: all sources level-triggered; EDGE reads 0, writes ignored; W1C on PEND has no effect.
// STRUCTURE
//  Shared package: register index constants (MASK/PEND/EDGE/ISR), FSM state encoding (IDLE/REQ/SERVICE),
//   HWInt base bit (2).
//  One sub-module: hwint_prio_enc (NSRC-wide lowest-index one-hot priority encoder, combinational).
//  Synchroniser, pending latch, FSM and register file stay in hwint_ctrl.
// TESTING
//  MASK=6'h3F, irq_in[3]=1 level -> hwint=6'b001000 by cycle 4; exc_taken -> hwint=0, ISR=8, busy=1;
//   eret_commit -> busy=0, ISR=0, hwint re-asserts 6'b001000 if irq still high.
//  In REQ with WIN=bit3, raise irq_in[1] -> hwint stays 6'b001000 until exc_taken; after eret -> 6'b000010.
//  MASK=0, irq_in=6'h3F -> hwint=0, PEND=6'h3F; write MASK=6'h20 -> hwint=6'b100000 within 2 cycles.
//  Level irq_in[2] dropped in REQ before exc_taken -> IDLE, hwint=0 next cycle; same-cycle drop+exc_taken -> SERVICE.
//  HWINT_EDGE_EN, EDGE=1: 1-cycle pulse on irq_in[0] -> PEND[0]=1 held; exc_taken clears PEND[0];
//   W1C 32'h1 on pending source clears it, REQ->IDLE.
//  Reset asserted in SERVICE -> next cycle hwint=0, busy=0, MASK=0, reg_rdata for all indices = 0.

Source files
------------

// File: rtl/hwint_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hwint_ctrl_pkg
//  Description : Shared definitions for the hardware interrupt controller:
//                register word indices, FSM state encoding and the position
//                of the controller outputs within CP0 HWInt.
//  Revision    : 1.0  initial release
// ============================================================================
package hwint_ctrl_pkg;

  // Register word indices on reg_addr
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_ISR  = 2'd3;

  // Source i lands on CP0 HWInt bit (HWINT_BASE + i); hwint is HWINT_W wide
  localparam int HWINT_BASE = 2;
  localparam int HWINT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage : hwint_ctrl_pkg
`default_nettype wire

// File: rtl/hwint_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hwint_ctrl_if
//  Description : Bus bundle between the controller and its neighbours:
//                bridge register port (reg_we/reg_addr/reg_wdata/reg_rdata)
//                and the CP0 side (exc_taken, eret_commit, hwint, busy).
//                master = bridge/CP0 side, slave = interrupt controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface hwint_ctrl_if;
  import hwint_ctrl_pkg::*;

  logic               reg_we;
  logic [1:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [31:0]        reg_rdata;
  logic               exc_taken;
  logic               eret_commit;
  logic [HWINT_W-1:0] hwint;
  logic               busy;

  modport master (
    output reg_we, reg_addr, reg_wdata, exc_taken, eret_commit,
    input  reg_rdata, hwint, busy
  );

  modport slave (
    input  reg_we, reg_addr, reg_wdata, exc_taken, eret_commit,
    output reg_rdata, hwint, busy
  );

endinterface : hwint_ctrl_if
`default_nettype wire

// File: rtl/hwint_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : hwint_prio_enc
//  Description : Combinational fixed-priority encoder. Returns the lowest
//                set bit of req as a one-hot grant (bit 0 wins); zero when
//                req is zero.
//  Ports       : req   [N-1:0] in   request vector
//                grant [N-1:0] out  one-hot or zero
//  Revision    : 1.0  initial release
// ============================================================================
module hwint_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule : hwint_prio_enc
`default_nettype wire

// File: rtl/hwint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hwint_ctrl
//  Description : Interrupt controller feeding CP0 HWInt[7:2]. Synchronises
//                raw device IRQs, latches them into PEND, masks them, picks
//                one winner by fixed priority and holds it on hwint until CP0
//                accepts it; then tracks the in-service source in ISR until
//                eret commits.
//  Ports       : clk, reset (synchronous, active-high)
//                irq_in [NSRC-1:0]  raw asynchronous device requests
//                bus (hwint_ctrl_if.slave): register port + CP0 handshake
//  Config      : HWINT_EDGE_EN - when defined, the EDGE register selects
//                edge (1) or level (0) per source and PEND accepts W1C.
//                Otherwise every source is level-triggered, EDGE reads 0.
//  Revision    : 1.0  initial release
// ============================================================================
module hwint_ctrl
  import hwint_ctrl_pkg::*;
#(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  hwint_ctrl_if.slave     bus
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_irq_s;      // synchronised request
  logic [NSRC-1:0] r_irq_d;      // previous irq_s, for rising-edge detect
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_win;        // winner latched on IDLE->REQ
  logic [NSRC-1:0] r_isr;
  state_t          r_state;

  logic [NSRC-1:0] w_edge_mode;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_grant;
  logic [NSRC-1:0] w_win_nxt;
  logic [NSRC-1:0] w_isr_nxt;
  state_t          w_state_nxt;
  logic            w_wr_mask;
  logic            w_wr_pend;
  logic [31:0]     w_rdata;
  logic [HWINT_W-1:0] w_hwint;

  assign w_wr_mask = bus.reg_we && (bus.reg_addr == REG_MASK);
  assign w_wr_pend = bus.reg_we && (bus.reg_addr == REG_PEND);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser plus one history stage for edge detection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_irq_s <= '0;
      r_irq_d <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_irq_s <= r_sync1;
      r_irq_d <= r_irq_s;
    end
  end

  assign w_rise = r_irq_s & ~r_irq_d;

  // --------------------------------------------------------------------------
  // Edge/level select register
  // --------------------------------------------------------------------------
`ifdef HWINT_EDGE_EN
  logic [NSRC-1:0] r_edge;
  logic            w_wr_edge;

  assign w_wr_edge = bus.reg_we && (bus.reg_addr == REG_EDGE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge <= '0;
    end else if (w_wr_edge) begin
      r_edge <= bus.reg_wdata[NSRC-1:0];
    end
  end

  assign w_edge_mode = r_edge;
`else
  assign w_edge_mode = '0;
`endif

  // --------------------------------------------------------------------------
  // Pending latch. Level sources simply follow irq_s. Edge sources are set by
  // a rising edge and cleared by W1C or by CP0 accepting them; the set term
  // is OR-ed after the clear so a fresh edge in the clear cycle survives.
  // --------------------------------------------------------------------------
  always_comb begin
    w_clr = '0;
    if (w_wr_pend) begin
      w_clr = bus.reg_wdata[NSRC-1:0];
    end
    if ((r_state == ST_REQ) && bus.exc_taken) begin
      w_clr = w_clr | r_win;
    end
  end

  assign w_pend_nxt = (w_edge_mode & (w_rise | (r_pend & ~w_clr)))
                    | (~w_edge_mode & r_irq_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_mask <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_wr_mask) begin
        r_mask <= bus.reg_wdata[NSRC-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign w_elig = r_pend & r_mask;

  hwint_prio_enc #(
    .N (NSRC)
  ) u_prio_enc (
    .req   (w_elig),
    .grant (w_grant)
  );

  // --------------------------------------------------------------------------
  // Request / service FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_isr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_isr   <= w_isr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_isr_nxt   = r_isr;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt = ST_REQ;
          w_win_nxt   = w_grant;
        end
      end
      ST_REQ: begin
        // Acceptance beats a simultaneous loss of eligibility: CP0 has
        // already committed to the handler.
        if (bus.exc_taken) begin
          w_state_nxt = ST_SERVICE;
          w_isr_nxt   = r_win;
        end else if (~|(r_win & w_elig)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.eret_commit) begin
          w_state_nxt = ST_IDLE;
          w_isr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_hwint = '0;
    if (r_state == ST_REQ) begin
      w_hwint[NSRC-1:0] = r_win;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.reg_addr)
      REG_MASK: w_rdata[NSRC-1:0] = r_mask;
      REG_PEND: w_rdata[NSRC-1:0] = r_pend;
      REG_EDGE: w_rdata[NSRC-1:0] = w_edge_mode;
      REG_ISR:  w_rdata[NSRC-1:0] = r_isr;
      default:  w_rdata = '0;
    endcase
  end

  assign bus.hwint     = w_hwint;
  assign bus.busy      = (r_state == ST_SERVICE);
  assign bus.reg_rdata = w_rdata;

endmodule : hwint_ctrl
`default_nettype wire

// File: tb/tb_hwint_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hwint_ctrl
//  Description : Self-checking bench for hwint_ctrl. Directed scenarios and
//                randomized traffic, all compared every cycle against a
//                behavioural model of the controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hwint_ctrl;

`ifdef HWINT_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [5:0] irq_in;
  int         total;
  int         bad;

  hwint_ctrl_if bus ();

  hwint_ctrl #(
    .NSRC (6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [5:0] hist [0:2];   // irq_in as sampled 1, 2 and 3 edges ago
  logic [5:0] m_pend, m_mask, m_edge, m_win, m_isr;
  int         m_mode;       // 0 waiting, 1 requesting, 2 in service

  function automatic logic [5:0] lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) begin
      if (v[i]) return 6'(1 << i);
    end
    return 6'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_mask};
      2'd1:    return {26'd0, m_pend};
      2'd2:    return {26'd0, m_edge};
      default: return {26'd0, m_isr};
    endcase
  endfunction

  task automatic model_update();
    logic [5:0] elig, rise, clr, npend;
    if (reset) begin
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      m_pend = 0; m_mask = 0; m_edge = 0; m_win = 0; m_isr = 0; m_mode = 0;
      return;
    end
    elig = m_pend & m_mask;
    rise = hist[1] & ~hist[2];
    clr  = 0;
    if (EDGE_EN && bus.reg_we && bus.reg_addr == 2'd1) clr = bus.reg_wdata[5:0];
    if (m_mode == 1 && bus.exc_taken) clr = clr | m_win;
    for (int i = 0; i < 6; i++) begin
      if (m_edge[i]) npend[i] = rise[i] ? 1'b1 : (m_pend[i] & ~clr[i]);
      else           npend[i] = hist[1][i];
    end
    if (m_mode == 0) begin
      if (elig != 0) begin m_mode = 1; m_win = lowest(elig); end
    end else if (m_mode == 1) begin
      if (bus.exc_taken)           begin m_mode = 2; m_isr = m_win; end
      else if ((m_win & elig) == 0) m_mode = 0;
    end else begin
      if (bus.eret_commit) begin m_mode = 0; m_isr = 0; end
    end
    if (bus.reg_we && bus.reg_addr == 2'd0) m_mask = bus.reg_wdata[5:0];
    if (EDGE_EN && bus.reg_we && bus.reg_addr == 2'd2) m_edge = bus.reg_wdata[5:0];
    m_pend  = npend;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq_in;
  endtask

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1ns later, pulses dropped.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_eq("hwint", {26'd0, bus.hwint}, {26'd0, (m_mode == 1) ? m_win : 6'd0});
    check_eq("busy", {31'd0, bus.busy}, {31'd0, (m_mode == 2)});
    check_eq("rdata", bus.reg_rdata, m_read(bus.reg_addr));
    bus.exc_taken   = 1'b0;
    bus.eret_commit = 1'b0;
    bus.reg_we      = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    step();
  endtask

  task automatic pulse_exc();
    bus.exc_taken = 1'b1;
    step();
  endtask

  task automatic pulse_eret();
    bus.eret_commit = 1'b1;
    step();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    irq_in = 6'd0;
    bus.reg_we = 1'b0; bus.reg_addr = 2'd0; bus.reg_wdata = 32'd0;
    bus.exc_taken = 1'b0; bus.eret_commit = 1'b0;
    steps(2);
    reset = 1'b0;
    check_eq("rst_hwint", {26'd0, bus.hwint}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);

    // Single level source through request, service and re-request
    wr(2'd0, 32'h3F);
    bus.reg_addr = 2'd1;
    irq_in = 6'h08;
    steps(3);
    check_eq("lvl_pend_c3", bus.reg_rdata, 32'h08);
    check_eq("lvl_hwint_c3", {26'd0, bus.hwint}, 32'h0);
    step();
    check_eq("lvl_hwint_c4", {26'd0, bus.hwint}, 32'h08);
    pulse_exc();
    bus.reg_addr = 2'd3;
    #1;
    check_eq("svc_isr", bus.reg_rdata, 32'h08);
    check_eq("svc_hwint", {26'd0, bus.hwint}, 32'h0);
    check_eq("svc_busy", {31'd0, bus.busy}, 32'h1);
    steps(2);
    pulse_eret();
    check_eq("eret_busy", {31'd0, bus.busy}, 32'h0);
    check_eq("eret_isr", bus.reg_rdata, 32'h0);
    step();
    check_eq("rereq_hwint", {26'd0, bus.hwint}, 32'h08);

    // Higher-priority arrival while requesting does not re-arbitrate
    irq_in = 6'h0A;
    steps(5);
    check_eq("noarb_hwint", {26'd0, bus.hwint}, 32'h08);
    pulse_exc();
    pulse_eret();
    step();
    check_eq("prio_hwint", {26'd0, bus.hwint}, 32'h02);
    irq_in = 6'h00;
    pulse_exc();
    pulse_eret();
    steps(6);

    // Masked sources stay pending; unmasking one raises it
    wr(2'd0, 32'h0);
    irq_in = 6'h3F;
    steps(4);
    bus.reg_addr = 2'd1;
    #1;
    check_eq("mask_pend", bus.reg_rdata, 32'h3F);
    check_eq("mask_hwint", {26'd0, bus.hwint}, 32'h0);
    wr(2'd0, 32'h20);
    step();
    check_eq("unmask_hwint", {26'd0, bus.hwint}, 32'h20);
    irq_in = 6'h00;
    pulse_exc();
    pulse_eret();
    steps(6);

    // Level drop while requesting, then drop coinciding with acceptance
    wr(2'd0, 32'h04);
    irq_in = 6'h04;
    steps(4);
    check_eq("drop_req", {26'd0, bus.hwint}, 32'h04);
    irq_in = 6'h00;
    steps(3);
    check_eq("drop_hold", {26'd0, bus.hwint}, 32'h04);
    step();
    check_eq("drop_idle", {26'd0, bus.hwint}, 32'h0);
    irq_in = 6'h04;
    steps(4);
    irq_in = 6'h00;
    steps(3);
    pulse_exc();
    check_eq("race_busy", {31'd0, bus.busy}, 32'h1);
    pulse_eret();
    steps(2);

    // Reset while in service
    irq_in = 6'h04;
    steps(4);
    pulse_exc();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_svc_hwint", {26'd0, bus.hwint}, 32'h0);
    check_eq("rst_svc_busy", {31'd0, bus.busy}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus.reg_addr = 2'(a);
      #1;
      check_eq("rst_svc_reg", bus.reg_rdata, 32'h0);
    end
    irq_in = 6'h00;
    steps(4);

`ifdef HWINT_EDGE_EN
    // Edge mode: pulse held in PEND, cleared by acceptance and by W1C
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h1);
    bus.reg_addr = 2'd1;
    irq_in = 6'h01;
    step();
    irq_in = 6'h00;
    steps(6);
    check_eq("edge_pend_held", bus.reg_rdata, 32'h1);
    check_eq("edge_hwint", {26'd0, bus.hwint}, 32'h1);
    pulse_exc();
    check_eq("edge_exc_clr", bus.reg_rdata, 32'h0);
    pulse_eret();
    irq_in = 6'h01;
    step();
    irq_in = 6'h00;
    steps(3);
    check_eq("edge_req2", {26'd0, bus.hwint}, 32'h1);
    wr(2'd1, 32'h1);
    check_eq("w1c_pend", bus.reg_rdata, 32'h0);
    step();
    check_eq("w1c_idle", {26'd0, bus.hwint}, 32'h0);
`endif

    // Randomized traffic against the model
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        int k;
        k = int'($urandom_range(5));
        irq_in[k] = ~irq_in[k];
      end
      bus.exc_taken   = ($urandom_range(5) == 0);
      bus.eret_commit = ($urandom_range(7) == 0);
      bus.reg_addr    = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) begin
        bus.reg_we    = 1'b1;
        bus.reg_wdata = $urandom;
      end
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hwint_ctrl
`default_nettype wire
